fetch_pc_stage: RTL and testbench

- Instruction-fetch stage that sits directly downstream of the branch comparator.
- Consumes the comparator's select_pc_mux code and holds the program counter (PC).
- Drives the instruction-memory request handshake and owns the IF/ID pipeline register.
- Handles redirects, hazard stalls, wrong-path squash and halt.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_pc_stage_if.sv | 13 +
 rtl/fetch_pc_stage_next_pc_mux.sv | 21 ++
 rtl/fetch_pc_stage.sv | 90 +++++++++
 tb/tb_fetch_pc_stage.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the fetch stage: next-PC select codes and the fetch FSM state.
package fetch_pkg;

    typedef logic [1:0] pc_sel_t;

    localparam pc_sel_t PC_SEL_INC    = 2'b00;
    localparam pc_sel_t PC_SEL_BRANCH = 2'b01;
    localparam pc_sel_t PC_SEL_JUMP   = 2'b10;

    typedef enum logic [1:0] {
        BOOT  = 2'b00,
        FETCH = 2'b01,
        HALT  = 2'b10
    } fetch_state_t;

    function automatic logic is_redirect(input pc_sel_t sel);
        return (sel == PC_SEL_BRANCH) || (sel == PC_SEL_JUMP);
    endfunction

endpackage

// File: rtl/fetch_pc_stage_if.sv
// Instruction-memory request bus: combinational req/addr out, ack/rdata back in the same cycle.
interface fetch_pc_stage_if #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 32
);
  logic               req;
  logic [ADDR_W-1:0]  addr;
  logic               ack;
  logic [INSTR_W-1:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/fetch_pc_stage_next_pc_mux.sv
// Next-PC selection; the reserved code 2'b11 falls back to sequential PC+1.
module next_pc_mux
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic [ADDR_W-1:0] pc,
  input  pc_sel_t           sel,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic [ADDR_W-1:0] jump_target,
  output logic [ADDR_W-1:0] next_pc
);
  always_comb begin
    next_pc = pc + ADDR_W'(1);
    case (sel)
      PC_SEL_BRANCH: next_pc = branch_target;
      PC_SEL_JUMP:   next_pc = jump_target;
      default:       next_pc = pc + ADDR_W'(1);
    endcase
  end
endmodule

// File: rtl/fetch_pc_stage.sv
// Fetch stage: PC register, BOOT/FETCH/HALT FSM, imem request and the IF/ID register.
module fetch_pc_stage
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  pc_sel_t            select_pc_mux,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic [ADDR_W-1:0]  jump_target,
  input  logic               stall,
  input  logic               halt,
  fetch_pc_stage_if.master   imem,
  output logic               if_id_valid,
  output logic [ADDR_W-1:0]  if_id_pc,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic               halted
);
  fetch_state_t       state_q, state_n;
  logic [ADDR_W-1:0]  pc_q, pc_n, next_pc;
  logic               valid_n;
  logic [ADDR_W-1:0]  if_pc_n;
  logic [INSTR_W-1:0] if_instr_n;
  logic               redirect, can_accept, xfer;

  next_pc_mux #(.ADDR_W(ADDR_W)) u_next_pc_mux (
    .pc            (pc_q),
    .sel           (select_pc_mux),
    .branch_target (branch_target),
    .jump_target   (jump_target),
    .next_pc       (next_pc)
  );

  assign redirect   = is_redirect(select_pc_mux);
  assign can_accept = !if_id_valid || !stall;
  // Redirect suppresses the request so a wrong-path word can never be accepted.
  assign imem.req   = (state_q == FETCH) && can_accept && !redirect && !halt;
  assign imem.addr  = pc_q;
  assign xfer       = imem.req && imem.ack;
  assign halted     = (state_q == HALT);

  always_comb begin
    state_n    = state_q;
    pc_n       = pc_q;
    valid_n    = if_id_valid;
    if_pc_n    = if_id_pc;
    if_instr_n = if_id_instr;
    case (state_q)
      BOOT: state_n = FETCH;
      FETCH: begin
        if (halt) begin
          state_n = HALT;
          valid_n = 1'b0;
        end else if (redirect) begin
          pc_n    = next_pc;
          valid_n = 1'b0;
        end else if (xfer) begin
          // select is 00 or 11 here, so the mux yields pc+1 with natural wrap.
          pc_n       = next_pc;
          valid_n    = 1'b1;
          if_pc_n    = pc_q;
          if_instr_n = imem.rdata;
        end else if (!stall) begin
          valid_n = 1'b0;
        end
      end
      HALT:    state_n = HALT;
      default: state_n = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= BOOT;
      pc_q        <= RESET_PC;
      if_id_valid <= 1'b0;
      if_id_pc    <= '0;
      if_id_instr <= '0;
    end else begin
      state_q     <= state_n;
      pc_q        <= pc_n;
      if_id_valid <= valid_n;
      if_id_pc    <= if_pc_n;
      if_id_instr <= if_instr_n;
    end
  end
endmodule

// File: tb/tb_fetch_pc_stage.sv
// Directed bench: driver pushes expected IF/ID contents per accepted fetch, monitor pops and compares.
module tb_fetch_pc_stage;
  import fetch_pkg::*;

  typedef struct packed {
    logic [15:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  pc_sel_t     select_pc_mux = PC_SEL_INC;
  logic [15:0] branch_target = '0;
  logic [15:0] jump_target = '0;
  logic        stall = 1'b0;
  logic        halt = 1'b0;
  logic        if_id_valid;
  logic [15:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        halted;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];

  fetch_pc_stage_if #(.ADDR_W(16), .INSTR_W(32)) imem ();

  fetch_pc_stage #(.ADDR_W(16), .INSTR_W(32), .RESET_PC(16'h0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .select_pc_mux (select_pc_mux),
    .branch_target (branch_target),
    .jump_target   (jump_target),
    .stall         (stall),
    .halt          (halt),
    .imem          (imem),
    .if_id_valid   (if_id_valid),
    .if_id_pc      (if_id_pc),
    .if_id_instr   (if_id_instr),
    .halted        (halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle: drive inputs shortly after the edge, check the combinational request.
  task automatic cyc(input pc_sel_t sel, input logic [15:0] bt, input logic [15:0] jt,
                     input logic st, input logic hl, input logic ack,
                     input logic exp_req, input logic [15:0] exp_addr, input string tag);
    exp_t e;
    @(posedge clk);
    #2;
    select_pc_mux = sel;
    branch_target = bt;
    jump_target   = jt;
    stall         = st;
    halt          = hl;
    imem.ack      = ack;
    imem.rdata    = {16'h0000, exp_addr} + 32'h100;
    #1;
    check({tag, " req"}, {31'b0, imem.req}, {31'b0, exp_req});
    check({tag, " addr"}, {16'b0, imem.addr}, {16'b0, exp_addr});
    if (exp_req && ack) begin
      e.pc    = exp_addr;
      e.instr = {16'h0000, exp_addr} + 32'h100;
      sb.push_back(e);
    end
  endtask

  initial begin : monitor
    logic xfer;
    exp_t e;
    forever begin
      @(negedge clk);
      xfer = imem.req && imem.ack;
      @(posedge clk);
      #1;
      if (xfer) begin
        if (sb.size() == 0) begin
          check("unexpected transfer", {16'b0, if_id_pc}, 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check("ifid valid", {31'b0, if_id_valid}, 32'd1);
          check("ifid pc", {16'b0, if_id_pc}, {16'b0, e.pc});
          check("ifid instr", if_id_instr, e.instr);
        end
      end
    end
  end

  initial begin : driver
    imem.ack   = 1'b0;
    imem.rdata = '0;
    @(posedge clk);
    #2;
    check("rst req", {31'b0, imem.req}, 32'd0);
    check("rst addr", {16'b0, imem.addr}, 32'd0);
    check("rst valid", {31'b0, if_id_valid}, 32'd0);
    check("rst ifpc", {16'b0, if_id_pc}, 32'd0);
    check("rst instr", if_id_instr, 32'd0);
    check("rst halted", {31'b0, halted}, 32'd0);
    rst = 1'b0;
    imem.ack = 1'b1;
    imem.rdata = 32'h100;
    #1;
    check("boot req", {31'b0, imem.req}, 32'd0);

    // Streaming fetch 0..4 with ack held high.
    for (int a = 0; a < 5; a++) cyc(PC_SEL_INC, 0, 0, 0, 0, 1, 1, 16'(a), "stream");

    // Memory wait at pc=5.
    cyc(PC_SEL_INC, 0, 0, 0, 0, 0, 1, 16'h5, "wait1");
    cyc(PC_SEL_INC, 0, 0, 0, 0, 0, 1, 16'h5, "wait2");
    check("wait2 valid", {31'b0, if_id_valid}, 32'd0);
    cyc(PC_SEL_INC, 0, 0, 0, 0, 0, 1, 16'h5, "wait3");
    check("wait3 valid", {31'b0, if_id_valid}, 32'd0);
    for (int a = 5; a < 8; a++) cyc(PC_SEL_INC, 0, 0, 0, 0, 1, 1, 16'(a), "resume");

    // Stall with IF/ID holding pc=7.
    cyc(PC_SEL_INC, 0, 0, 1, 0, 1, 0, 16'h8, "stall1");
    cyc(PC_SEL_INC, 0, 0, 1, 0, 1, 0, 16'h8, "stall2");
    check("stall hold valid", {31'b0, if_id_valid}, 32'd1);
    check("stall hold pc", {16'b0, if_id_pc}, 32'h7);
    check("stall hold instr", if_id_instr, 32'h107);
    for (int a = 8; a < 16; a++) cyc(PC_SEL_INC, 0, 0, 0, 0, 1, 1, 16'(a), "run");

    // Branch at pc=0x10 while stalled: squash, no wrong-path transfer.
    cyc(PC_SEL_BRANCH, 16'h0040, 0, 1, 0, 1, 0, 16'h10, "branch");
    cyc(PC_SEL_INC, 0, 0, 0, 0, 1, 1, 16'h40, "target");
    check("squash valid", {31'b0, if_id_valid}, 32'd0);

    // Jump to 0xFFFF, wrap to 0, reserved select acts as PC+1.
    cyc(PC_SEL_JUMP, 0, 16'hFFFF, 0, 0, 1, 0, 16'h41, "jump");
    cyc(PC_SEL_INC, 0, 0, 0, 0, 1, 1, 16'hFFFF, "top");
    cyc(2'b11, 0, 0, 0, 0, 1, 1, 16'h0000, "wrap");
    cyc(PC_SEL_INC, 0, 0, 0, 0, 1, 1, 16'h0001, "rsvd");

    // Halt wins over a simultaneous jump.
    cyc(PC_SEL_JUMP, 0, 16'h1234, 0, 1, 1, 0, 16'h0002, "halt");
    cyc(PC_SEL_INC, 0, 0, 0, 0, 1, 0, 16'h0002, "halted1");
    check("halted flag", {31'b0, halted}, 32'd1);
    check("halted valid", {31'b0, if_id_valid}, 32'd0);
    cyc(PC_SEL_BRANCH, 16'h0077, 0, 0, 0, 1, 0, 16'h0002, "halted2");
    cyc(PC_SEL_INC, 0, 0, 0, 0, 1, 0, 16'h0002, "halted3");

    // Reset recovery.
    @(posedge clk);
    #2;
    imem.ack = 1'b0;
    rst = 1'b1;
    #1;
    check("rerst addr", {16'b0, imem.addr}, 32'd0);
    check("rerst halted", {31'b0, halted}, 32'd0);
    check("rerst req", {31'b0, imem.req}, 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    imem.ack = 1'b1;
    #1;
    check("reboot req", {31'b0, imem.req}, 32'd0);
    cyc(PC_SEL_INC, 0, 0, 0, 0, 1, 1, 16'h0000, "refetch");
    cyc(PC_SEL_INC, 0, 0, 0, 0, 0, 1, 16'h0001, "drain1");
    cyc(PC_SEL_INC, 0, 0, 0, 0, 0, 1, 16'h0001, "drain2");
    check("scoreboard empty", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
